// File: rtl/img_rsz_ctrl.sv
// Sequencer for a block-averaging downscaler: walks a (32<<w) x (32<<h) source frame, then divides and forwards 32x32 block sums.
// Optional macro IMG_RSZ_CTRL_CFG_CHECK_EN: reject shifts above 5 with a sticky cfg_err instead of saturating them.
module img_rsz_ctrl #(
    parameter int IMG_WIDTH_IDX_W      = 10,
    parameter int IMG_HEIGHT_IDX_W     = 10,
    parameter int RSZ_IMG_WIDTH_IDX_W  = 5,
    parameter int RSZ_IMG_HEIGHT_IDX_W = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_cfg_start,
    input  logic                            i_cfg_abort,
    input  logic [2:0]                      i_cfg_w_shft,
    input  logic [2:0]                      i_cfg_h_shft,
    input  logic                            i_pxl_vld,
    output logic                            o_pxl_rdy,
    output logic                            o_acc_en,
    output logic                            o_acc_first,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  o_acc_blk_x,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] o_acc_blk_y,
    output logic                            o_div_start,
    output logic [3:0]                      o_div_shft,
    input  logic                            i_div_done,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  o_div_blk_x,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] o_div_blk_y,
    output logic                            o_rsz_vld,
    input  logic                            i_rsz_rdy,
    output logic                            o_busy,
    output logic                            o_frame_done,
    output logic                            o_cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV_REQ,
        DIV_WAIT,
        FWD
    } StateT;

    StateT                           r_state;
    StateT                           w_stateNxt;
    logic [IMG_WIDTH_IDX_W-1:0]      r_col;
    logic [IMG_WIDTH_IDX_W-1:0]      w_colNxt;
    logic [IMG_HEIGHT_IDX_W-1:0]     r_row;
    logic [IMG_HEIGHT_IDX_W-1:0]     w_rowNxt;
    logic [2:0]                      r_wShft;
    logic [2:0]                      w_wShftNxt;
    logic [2:0]                      r_hShft;
    logic [2:0]                      w_hShftNxt;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  r_blkX;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  w_blkXNxt;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] r_blkY;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] w_blkYNxt;

    logic                            w_accept;
    logic                            w_startOk;
    logic                            w_colLast;
    logic                            w_rowLast;
    logic                            w_colLow;
    logic                            w_rowLow;
    logic                            w_blkXLast;
    logic                            w_blkYLast;
    logic [2:0]                      w_wShftSat;
    logic [2:0]                      w_hShftSat;

    assign w_wShftSat = (i_cfg_w_shft > 3'd5) ? 3'd5 : i_cfg_w_shft;
    assign w_hShftSat = (i_cfg_h_shft > 3'd5) ? 3'd5 : i_cfg_h_shft;

`ifdef IMG_RSZ_CTRL_CFG_CHECK_EN
    logic w_cfgBad;
    logic r_cfgErr;

    assign w_cfgBad  = (i_cfg_w_shft > 3'd5) || (i_cfg_h_shft > 3'd5);
    assign w_startOk = i_cfg_start && !w_cfgBad;

    // Sticky until the next start request that is actually taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfgErr <= 1'b0;
        end else if ((r_state == IDLE) && i_cfg_start && !i_cfg_abort) begin
            r_cfgErr <= w_cfgBad;
        end
    end

    assign o_cfg_err = r_cfgErr;
`else
    assign w_startOk = i_cfg_start;
    assign o_cfg_err = 1'b0;
`endif

    assign w_accept   = i_pxl_vld && (r_state == ACCUM);
    assign w_colLast  = (r_col == IMG_WIDTH_IDX_W'((32'd32 << r_wShft) - 32'd1));
    assign w_rowLast  = (r_row == IMG_HEIGHT_IDX_W'((32'd32 << r_hShft) - 32'd1));
    assign w_colLow   = ((r_col & IMG_WIDTH_IDX_W'((32'd1 << r_wShft) - 32'd1)) == '0);
    assign w_rowLow   = ((r_row & IMG_HEIGHT_IDX_W'((32'd1 << r_hShft) - 32'd1)) == '0);
    assign w_blkXLast = (r_blkX == '1);
    assign w_blkYLast = (r_blkY == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_wShft <= '0;
            r_hShft <= '0;
            r_blkX  <= '0;
            r_blkY  <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_col   <= w_colNxt;
            r_row   <= w_rowNxt;
            r_wShft <= w_wShftNxt;
            r_hShft <= w_hShftNxt;
            r_blkX  <= w_blkXNxt;
            r_blkY  <= w_blkYNxt;
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        w_colNxt   = r_col;
        w_rowNxt   = r_row;
        w_wShftNxt = r_wShft;
        w_hShftNxt = r_hShft;
        w_blkXNxt  = r_blkX;
        w_blkYNxt  = r_blkY;

        case (r_state)
            IDLE: begin
                if (w_startOk) begin
                    w_stateNxt = ACCUM;
                    w_wShftNxt = w_wShftSat;
                    w_hShftNxt = w_hShftSat;
                    w_colNxt   = '0;
                    w_rowNxt   = '0;
                    w_blkXNxt  = '0;
                    w_blkYNxt  = '0;
                end
            end
            // Raster walk; both counters wrap to 0 on the last pixel so they read 0 outside ACCUM.
            ACCUM: begin
                if (w_accept) begin
                    if (w_colLast) begin
                        w_colNxt = '0;
                        if (w_rowLast) begin
                            w_rowNxt   = '0;
                            w_stateNxt = DIV_REQ;
                            w_blkXNxt  = '0;
                            w_blkYNxt  = '0;
                        end else begin
                            w_rowNxt = r_row + IMG_HEIGHT_IDX_W'(1);
                        end
                    end else begin
                        w_colNxt = r_col + IMG_WIDTH_IDX_W'(1);
                    end
                end
            end
            DIV_REQ: begin
                w_stateNxt = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (i_div_done) begin
                    w_stateNxt = FWD;
                end
            end
            FWD: begin
                if (i_rsz_rdy) begin
                    if (w_blkXLast && w_blkYLast) begin
                        w_stateNxt = IDLE;
                        w_blkXNxt  = '0;
                        w_blkYNxt  = '0;
                    end else begin
                        w_stateNxt = DIV_REQ;
                        if (w_blkXLast) begin
                            w_blkXNxt = '0;
                            w_blkYNxt = r_blkY + RSZ_IMG_HEIGHT_IDX_W'(1);
                        end else begin
                            w_blkXNxt = r_blkX + RSZ_IMG_WIDTH_IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_stateNxt = IDLE;
            end
        endcase

        if (i_cfg_abort) begin
            w_stateNxt = IDLE;
            w_colNxt   = '0;
            w_rowNxt   = '0;
            w_blkXNxt  = '0;
            w_blkYNxt  = '0;
        end
    end

    // acc_first is qualified by ACCUM so the cleared counters do not flag it while idle.
    assign o_pxl_rdy    = (r_state == ACCUM);
    assign o_acc_en     = i_pxl_vld && o_pxl_rdy;
    assign o_acc_first  = (r_state == ACCUM) && w_colLow && w_rowLow;
    assign o_acc_blk_x  = RSZ_IMG_WIDTH_IDX_W'(r_col >> r_wShft);
    assign o_acc_blk_y  = RSZ_IMG_HEIGHT_IDX_W'(r_row >> r_hShft);
    assign o_div_start  = (r_state == DIV_REQ);
    assign o_div_shft   = (r_state == IDLE) ? 4'd0 : (4'(r_wShft) + 4'(r_hShft));
    assign o_div_blk_x  = r_blkX;
    assign o_div_blk_y  = r_blkY;
    assign o_rsz_vld    = (r_state == FWD);
    assign o_busy       = (r_state != IDLE);
    assign o_frame_done = (r_state == FWD) && i_rsz_rdy && w_blkXLast && w_blkYLast && !i_cfg_abort;

endmodule

// File: tb/tb_img_rsz_ctrl.sv
// Self-checking bench for img_rsz_ctrl: a pixel/block-count model checked every cycle plus directed frame scenarios.
module tb_img_rsz_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_cfg_start = 1'b0;
    logic       i_cfg_abort = 1'b0;
    logic [2:0] i_cfg_w_shft = '0;
    logic [2:0] i_cfg_h_shft = '0;
    logic       i_pxl_vld = 1'b0;
    logic       o_pxl_rdy;
    logic       o_acc_en;
    logic       o_acc_first;
    logic [4:0] o_acc_blk_x;
    logic [4:0] o_acc_blk_y;
    logic       o_div_start;
    logic [3:0] o_div_shft;
    logic       i_div_done = 1'b0;
    logic [4:0] o_div_blk_x;
    logic [4:0] o_div_blk_y;
    logic       o_rsz_vld;
    logic       i_rsz_rdy = 1'b1;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_cfg_err;

    always #5 clk = ~clk;

    img_rsz_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_start  (i_cfg_start),
        .i_cfg_abort  (i_cfg_abort),
        .i_cfg_w_shft (i_cfg_w_shft),
        .i_cfg_h_shft (i_cfg_h_shft),
        .i_pxl_vld    (i_pxl_vld),
        .o_pxl_rdy    (o_pxl_rdy),
        .o_acc_en     (o_acc_en),
        .o_acc_first  (o_acc_first),
        .o_acc_blk_x  (o_acc_blk_x),
        .o_acc_blk_y  (o_acc_blk_y),
        .o_div_start  (o_div_start),
        .o_div_shft   (o_div_shft),
        .i_div_done   (i_div_done),
        .o_div_blk_x  (o_div_blk_x),
        .o_div_blk_y  (o_div_blk_y),
        .o_rsz_vld    (o_rsz_vld),
        .i_rsz_rdy    (i_rsz_rdy),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_cfg_err    (o_cfg_err)
    );

    int checks = 0;
    int failures = 0;

    // Model state: what the frame should look like, from pixel and block counts alone.
    bit mActive = 1'b0;
    int mWs = 0;
    int mHs = 0;
    int mPix = 0;
    int mBlk = 0;
    int mDivStarts = 0;
    int mFirstCnt = 0;
    int mXfers = 0;
    int firstDivPix = -1;
    int doneCnt = 0;
    bit capFirst [0:1099];
    int capBx    [0:1099];
    int capBy    [0:1099];

    bit respEn = 1'b1;
    bit manualDone = 1'b0;
    int respLat = 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dutOutputs();
        return {o_pxl_rdy, o_acc_en, o_acc_first, o_acc_blk_x, o_acc_blk_y, o_div_start, o_div_shft,
                o_div_blk_x, o_div_blk_y, o_rsz_vld, o_busy, o_frame_done, o_cfg_err};
    endfunction

    // Divider stand-in: answers each div_start after respLat cycles unless manually driven.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            if (respEn && o_div_start) cd = respLat;
            @(posedge clk);
            #1;
            if (respEn) begin
                i_div_done = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) i_div_done = 1'b1;
                end
            end else begin
                i_div_done = manualDone;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        int w, h, total, col, row;
        bit expFirst;
        forever begin
            @(negedge clk);
            if (o_frame_done) doneCnt++;
            if (!mActive) begin
                checkOutput("idle_outputs", {o_busy, o_pxl_rdy, o_acc_en, o_div_start, o_rsz_vld, o_frame_done}, 0);
            end else begin
                w = 32 << mWs;
                h = 32 << mHs;
                total = w * h;
                checkOutput("busy", o_busy, 1);
                checkOutput("pxl_rdy", o_pxl_rdy, (mPix < total) ? 1 : 0);
                if (o_acc_en) begin
                    col = mPix % w;
                    row = mPix / w;
                    expFirst = ((col % (1 << mWs)) == 0) && ((row % (1 << mHs)) == 0);
                    checkOutput("acc_blk_x", o_acc_blk_x, col >> mWs);
                    checkOutput("acc_blk_y", o_acc_blk_y, row >> mHs);
                    checkOutput("acc_first", o_acc_first, expFirst);
                    if (mPix < 1100) begin
                        capFirst[mPix] = o_acc_first;
                        capBx[mPix]    = o_acc_blk_x;
                        capBy[mPix]    = o_acc_blk_y;
                    end
                    if (o_acc_first) mFirstCnt++;
                    mPix++;
                end
                if (o_div_start) begin
                    if (firstDivPix < 0) firstDivPix = mPix;
                    checkOutput("div_after_accum", mPix, total);
                    checkOutput("div_shft", o_div_shft, mWs + mHs);
                    checkOutput("div_blk", {o_div_blk_y, o_div_blk_x}, {5'(mBlk / 32), 5'(mBlk % 32)});
                    checkOutput("div_once_per_blk", mDivStarts, mBlk);
                    mDivStarts++;
                end
                if (o_rsz_vld) begin
                    checkOutput("rsz_after_accum", mPix, total);
                    checkOutput("rsz_blk", {o_div_blk_y, o_div_blk_x}, {5'(mBlk / 32), 5'(mBlk % 32)});
                end
                if (o_rsz_vld && i_rsz_rdy) begin
                    checkOutput("frame_done_edge", o_frame_done, (mBlk == 1023) ? 1 : 0);
                    checkOutput("div_before_xfer", mDivStarts, mBlk + 1);
                    mBlk++;
                    mXfers++;
                    if (mBlk == 1024) mActive = 1'b0;
                end else begin
                    checkOutput("frame_done_quiet", o_frame_done, 0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] ws, input logic [2:0] hs);
        i_cfg_w_shft = ws;
        i_cfg_h_shft = hs;
        i_cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        i_cfg_start = 1'b0;
    endtask

    task automatic startFrame(input int ws, input int hs);
        applyStimulus(3'(ws), 3'(hs));
        mWs = (ws > 5) ? 5 : ws;
        mHs = (hs > 5) ? 5 : hs;
        mPix = 0;
        mBlk = 0;
        mDivStarts = 0;
        mFirstCnt = 0;
        mXfers = 0;
        firstDivPix = -1;
        mActive = 1'b1;
    endtask

    task automatic streamPixels(input int target, input bit toggle);
        int guard;
        bit ph;
        guard = 0;
        ph = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mPix >= target || guard > 40000) break;
            ph = ~ph;
            i_pxl_vld = toggle ? ph : 1'b1;
            guard++;
        end
        i_pxl_vld = 1'b0;
        checkOutput("stream_timeout", (mPix >= target) ? 1 : 0, 1);
    endtask

    task automatic waitIdle(input int budget);
        int g;
        g = 0;
        while (mActive && g < budget) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("frame_timeout", mActive, 0);
        if (mActive) mActive = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_after_frame", o_busy, 0);
    endtask

    task automatic abortFrame();
        i_cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        i_cfg_abort = 1'b0;
        mActive = 1'b0;
        checkOutput("abort_busy", o_busy, 0);
    endtask

    initial begin
        int g;
        int doneBefore;

        #1;
        checkOutput("reset_outputs", dutOutputs(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", o_busy, 0);

        $display("[TB] frame shifts 0/0");
        startFrame(0, 0);
        streamPixels(1024, 1'b0);
        waitIdle(6000);
        checkOutput("f00_div_starts", mDivStarts, 1024);
        checkOutput("f00_xfers", mXfers, 1024);
        checkOutput("f00_first_count", mFirstCnt, 1024);
        checkOutput("f00_done_count", doneCnt, 1);
        checkOutput("f00_first_px5", capFirst[5], 1);
        checkOutput("f00_blk_px33", {capBy[33][4:0], capBx[33][4:0]}, {5'd1, 5'd1});

        $display("[TB] frame shifts 1/2 with toggling valid");
        startFrame(1, 2);
        streamPixels(8192, 1'b1);
        waitIdle(6000);
        checkOutput("f12_first_0_0", capFirst[0], 1);
        checkOutput("f12_first_1_0", capFirst[1], 0);
        checkOutput("f12_first_2_0", capFirst[2], 1);
        checkOutput("f12_first_0_1", capFirst[64], 0);
        checkOutput("f12_first_0_4", capFirst[256], 1);
        checkOutput("f12_blkx_col5", capBx[5], 2);
        checkOutput("f12_blky_row4", capBy[256], 1);
        checkOutput("f12_first_div_pix", firstDivPix, 8192);
        checkOutput("f12_first_count", mFirstCnt, 1024);
        checkOutput("f12_div_starts", mDivStarts, 1024);
        checkOutput("f12_done_count", doneCnt, 2);

        $display("[TB] abort during DIV_WAIT");
        respEn = 1'b0;
        manualDone = 1'b0;
        doneBefore = doneCnt;
        startFrame(0, 0);
        streamPixels(1024, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("div_wait_busy", o_busy, 1);
        checkOutput("div_wait_no_rsz", o_rsz_vld, 0);
        abortFrame();
        manualDone = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        manualDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("late_done_ignored", {o_busy, o_rsz_vld}, 0);
        checkOutput("abort_no_frame_done", doneCnt, doneBefore);
        respEn = 1'b1;

        $display("[TB] frame after abort with FWD stall");
        i_rsz_rdy = 1'b0;
        startFrame(0, 0);
        streamPixels(1024, 1'b0);
        g = 0;
        while (!o_rsz_vld && g < 50) begin
            @(negedge clk);
            g++;
        end
        checkOutput("stall_reached_fwd", o_rsz_vld, 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_vld", o_rsz_vld, 1);
            checkOutput("stall_blk", {o_div_blk_y, o_div_blk_x}, 0);
            checkOutput("stall_no_div", o_div_start, 0);
        end
        @(posedge clk);
        #1;
        i_rsz_rdy = 1'b1;
        waitIdle(6000);
        checkOutput("stall_frame_done", doneCnt, doneBefore + 1);
        checkOutput("stall_xfers", mXfers, 1024);

`ifdef IMG_RSZ_CTRL_CFG_CHECK_EN
        $display("[TB] oversize shift rejected");
        applyStimulus(3'd6, 3'd0);
        checkOutput("cfg_err_set", o_cfg_err, 1);
        checkOutput("cfg_err_busy", o_busy, 0);
        startFrame(0, 0);
        checkOutput("cfg_err_cleared", o_cfg_err, 0);
        abortFrame();
`else
        $display("[TB] oversize shift saturates");
        startFrame(6, 0);
        streamPixels(1030, 1'b0);
        checkOutput("sat_blkx_col1023", capBx[1023], 31);
        checkOutput("sat_blky_col1023", capBy[1023], 0);
        checkOutput("sat_blkx_wrap", capBx[1024], 0);
        checkOutput("sat_blky_wrap", capBy[1024], 1);
        checkOutput("sat_cfg_err", o_cfg_err, 0);
        abortFrame();
`endif

        $display("[TB] reset mid-ACCUM");
        startFrame(0, 0);
        streamPixels(17, 1'b0);
        checkOutput("col17_blkx", o_acc_blk_x, 17);
        mActive = 1'b0;
        i_pxl_vld = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_frame", dutOutputs(), 0);
        @(posedge clk);
        #1;
        i_pxl_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_idle", o_busy, 0);
        startFrame(0, 0);
        streamPixels(20, 1'b0);
        checkOutput("restart_col0", capBx[0], 0);
        checkOutput("restart_row0", capBy[0], 0);
        checkOutput("restart_col17", capBx[17], 17);
        abortFrame();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_rsz_ctrl.md
IMG_RSZ_CTRL -- requirements
Module: img_rsz_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH_IDX_W, default 10, the width of the source column counter.
REQ-002 The block SHALL have parameter IMG_HEIGHT_IDX_W, default 10, the width of the source row counter.
REQ-003 The block SHALL have parameter RSZ_IMG_WIDTH_IDX_W, default 5, the width of the resized column index.
REQ-004 The block SHALL have parameter RSZ_IMG_HEIGHT_IDX_W, default 5, the width of the resized row index.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-006 The block SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have cfg_start  in  1  frame start request, sampled in IDLE only.
REQ-008 The block SHALL have cfg_abort  in  1  synchronous abort, returns the block to IDLE.
REQ-009 The block SHALL have cfg_w_shft  in  3  log2(source width / 32).
REQ-010 The block SHALL have cfg_h_shft  in  3  log2(source height / 32).
REQ-011 The block SHALL have pxl_vld  in  1 and pxl_rdy  out  1, the source pixel handshake.
REQ-012 The block SHALL have acc_en  out  1  accumulate strobe, equal to pxl_vld & pxl_rdy.
REQ-013 The block SHALL have acc_first  out  1  first pixel of a block (overwrite rather than add).
REQ-014 The block SHALL have acc_blk_x  out  5 and acc_blk_y  out  5, the block index for accumulation.
REQ-015 The block SHALL have div_start  out  1, div_shft  out  4, div_done  in  1, the multi-cycle divider control.
REQ-016 The block SHALL have div_blk_x  out  5 and div_blk_y  out  5, the block under division or forwarding.
REQ-017 The block SHALL have rsz_vld  out  1 and rsz_rdy  in  1, the serial resized-pixel handshake.
REQ-018 The block SHALL have busy  out  1, frame_done  out  1 (pulse) and cfg_err  out  1 (sticky).

Function
REQ-019 The FSM SHALL have the states IDLE, ACCUM, DIV_REQ, DIV_WAIT, FWD.
REQ-020 In IDLE, cfg_start=1 with valid cfg SHALL latch the shifts, clear the counters and enter ACCUM on the next cycle; busy=1 outside IDLE.
REQ-021 In ACCUM, pxl_rdy SHALL be 1, and the counters SHALL be 0 in all other states.
REQ-022 Each accepted pixel SHALL advance col; col wraps at (32<<w_shft)-1 to 0 and increments row.
REQ-023 acc_blk_x SHALL equal col>>w_shft, acc_blk_y SHALL equal row>>h_shft, and acc_first SHALL be 1 when both low-bit fields of col/row are 0; all three are combinational from the current counters.
REQ-024 Acceptance at col=W-1, row=H-1 SHALL enter DIV_REQ with the block index = (0,0).
REQ-025 DIV_REQ SHALL pulse div_start for 1 cycle with div_shft=w_shft+h_shft, then enter DIV_WAIT.
REQ-026 DIV_WAIT SHALL hold until div_done=1, then enter FWD; div_done in any other state SHALL be ignored.
REQ-027 FWD SHALL hold rsz_vld=1 and the index stable until rsz_rdy=1.
REQ-028 On transfer, the block index SHALL advance raster x-first: not at (31,31) -> DIV_REQ; at (31,31) -> IDLE with a frame_done pulse in the same cycle.
REQ-029 cfg_start while busy SHALL be ignored; cfg_abort SHALL take priority over every transition, go to IDLE and clear the counters without issuing frame_done.
REQ-030 Exactly 1024 div_start pulses and 1024 rsz transfers SHALL occur per completed frame.

Reset
REQ-031 On rst_n=0, state=IDLE, counters=0, shifts=0, and all outputs SHALL be 0 (pxl_rdy, acc_*, div_*, rsz_vld, busy, frame_done, cfg_err).
REQ-032 Reset mid-frame SHALL discard progress; the first cycle after release SHALL be IDLE.

Configuration
REQ-033 With macro IMG_RSZ_CTRL_CFG_CHECK_EN defined, cfg_start with a shift >5 SHALL be rejected (stay IDLE) and set cfg_err, which is cleared by the next accepted cfg_start or by reset.
REQ-034 Without the macro, shifts >5 SHALL saturate to 5 and cfg_err SHALL be tied to 0.

Verification
REQ-035 Shifts 0/0, 1024 pixels streamed -> acc_first on every pixel, 1024 div_start pulses, frame_done after the 1024th rsz transfer.
REQ-036 Shifts 1/2 (64x128), pxl_vld toggling -> acc_blk_x=col>>1, acc_first at (0,0),(2,0),(0,4); DIV_REQ only after 8192 accepted pixels.
REQ-037 rsz_rdy=0 for 5 cycles in FWD -> rsz_vld and div_blk_x/y stable, no new div_start.
REQ-038 cfg_abort during DIV_WAIT, later div_done=1 -> IDLE, no rsz_vld and no frame_done; a following frame runs normally.
REQ-039 cfg_w_shft=6 -> with the macro: cfg_err=1, busy=0; without the macro: 2048-wide frame processed as shift 5.
REQ-040 rst_n asserted mid-ACCUM at col=17 -> all outputs 0 immediately; a new cfg_start restarts at col=0,row=0.
